// File: rtl/heap_pq_pkg.sv
// Shared opcodes, error codes and FSM state encoding for the heap priority queue.
package heap_pq_pkg;

  localparam logic [2:0] OP_PUSH    = 3'b000;
  localparam logic [2:0] OP_POP     = 3'b001;
  localparam logic [2:0] OP_PEEK    = 3'b010;
  localparam logic [2:0] OP_REPLACE = 3'b011;
  localparam logic [2:0] OP_CLEAR   = 3'b100;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UDF = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SIFT_UP,
    SIFT_DOWN,
    DONE
  } state_t;

endpackage

// File: rtl/heap_pq_cmp.sv
// Heap ordering comparator: picks the better of two children and tests the
// node against it. Sift-up reuses it with the child on the left input only.
module heap_pq_cmp
  import heap_pq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MIN_HEAP = 1
) (
  input  logic [DATA_W-1:0] node,
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  input  logic              left_v,
  input  logic              right_v,
  output logic              take_right,
  output logic              has_child,
  output logic              node_ok
);

  logic [DATA_W-1:0] best;

  // Equal keys count as in order, so ties never swap and the left child wins.
  function automatic logic in_order(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] c);
    return (MIN_HEAP != 0) ? (p <= c) : (p >= c);
  endfunction

  always_comb begin
    take_right = left_v && right_v && !in_order(left, right);
    best       = take_right ? right : left;
    has_child  = left_v;
    node_ok    = !left_v || in_order(node, best);
  end

endmodule

// File: rtl/heap_pq_engine.sv
// Binary-heap priority queue behind the custom-instruction interface; sifts
// one tree level per clock and reports completion with a one-cycle out_v.
module heap_pq_engine
  import heap_pq_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 16,
  parameter  int MIN_HEAP = 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_v,
  output logic              in_ready,
  input  logic [4:0]        rd,
  input  logic [2:0]        vrd1,
  input  logic [2:0]        vrd2,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_v,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_vrd1,
  output logic [2:0]        out_vrd2,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_err,
  output logic [CNT_W-1:0]  out_heap_size,
  output logic [DATA_W-1:0] out_top,
  output logic              out_empty,
  output logic              out_full
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int IDX_W  = CNT_W + 1;

  logic [DATA_W-1:0] heap [DEPTH];
  state_t            state, state_next;
  logic [CNT_W-1:0]  size, cursor, parent_idx, best_idx;
  logic [IDX_W-1:0]  left_idx, right_idx;
  logic              accept, empty, full;
  logic              left_v, right_v, take_right, has_child, node_ok;
  logic              up_term, down_term;
  logic [1:0]        req_err;
  logic [DATA_W-1:0] cur_key, par_key, left_key, right_key, best_key;
  logic [DATA_W-1:0] cmp_node, cmp_left;
  logic              cmp_left_v, cmp_right_v;

  assign empty         = (size == '0);
  assign full          = (size == CNT_W'(DEPTH));
  assign in_ready      = reset && (state == IDLE);
  assign out_v         = reset && (state == DONE);
  assign accept        = in_v && in_ready;
  assign out_heap_size = size;
  assign out_empty     = empty;
  assign out_full      = full;
  assign out_top       = empty ? '0 : heap[0];

  always_comb begin
    req_err = ERR_OK;
    case (vrd1)
      OP_PUSH:                     if (full)  req_err = ERR_OVF;
      OP_POP, OP_PEEK, OP_REPLACE: if (empty) req_err = ERR_UDF;
      OP_CLEAR:                    req_err = ERR_OK;
      default:                     req_err = ERR_ILL;
    endcase
  end

  // Tree navigation around the cursor; children past size are invalid.
  always_comb begin
    left_idx   = {cursor, 1'b1};
    right_idx  = left_idx + IDX_W'(1);
    left_v     = left_idx < {1'b0, size};
    right_v    = right_idx < {1'b0, size};
    parent_idx = (cursor - CNT_W'(1)) >> 1;
    cur_key    = heap[ADDR_W'(cursor)];
    par_key    = heap[ADDR_W'(parent_idx)];
    left_key   = heap[left_v ? ADDR_W'(left_idx) : '0];
    right_key  = heap[right_v ? ADDR_W'(right_idx) : '0];
    best_key   = take_right ? right_key : left_key;
    best_idx   = take_right ? right_idx[CNT_W-1:0] : left_idx[CNT_W-1:0];
    if (state == SIFT_UP) begin
      cmp_node    = par_key;
      cmp_left    = cur_key;
      cmp_left_v  = 1'b1;
      cmp_right_v = 1'b0;
    end else begin
      cmp_node    = cur_key;
      cmp_left    = left_key;
      cmp_left_v  = left_v;
      cmp_right_v = right_v;
    end
    up_term   = (cursor == '0) || node_ok;
    down_term = !has_child || node_ok;
  end

  heap_pq_cmp #(
    .DATA_W   (DATA_W),
    .MIN_HEAP (MIN_HEAP)
  ) u_cmp (
    .node       (cmp_node),
    .left       (cmp_left),
    .right      (right_key),
    .left_v     (cmp_left_v),
    .right_v    (cmp_right_v),
    .take_right (take_right),
    .has_child  (has_child),
    .node_ok    (node_ok)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err != ERR_OK)                           state_next = DONE;
        else if (vrd1 == OP_PUSH)                        state_next = SIFT_UP;
        else if (vrd1 == OP_POP || vrd1 == OP_REPLACE)   state_next = SIFT_DOWN;
        else                                             state_next = DONE;
      end
      SIFT_UP:   if (up_term)   state_next = DONE;
      SIFT_DOWN: if (down_term) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Control, size and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      size     <= '0;
      out_data <= '0;
      out_err  <= ERR_OK;
      out_rd   <= '0;
      out_vrd1 <= '0;
      out_vrd2 <= '0;
    end else if (accept) begin
      out_rd   <= rd;
      out_vrd1 <= vrd1;
      out_vrd2 <= vrd2;
      out_err  <= req_err;
      out_data <= '0;
      if (req_err == ERR_OK) begin
        case (vrd1)
          OP_PUSH:    size <= size + CNT_W'(1);
          OP_POP: begin
            out_data <= heap[0];
            size     <= size - CNT_W'(1);
          end
          OP_PEEK, OP_REPLACE: out_data <= heap[0];
          OP_CLEAR:   size <= '0;
          default:    size <= size;
        endcase
      end
    end
  end

  // Key array and cursor carry no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (accept && req_err == ERR_OK) begin
        case (vrd1)
          OP_PUSH: begin
            heap[ADDR_W'(size)] <= in_data;
            cursor              <= size;
          end
          OP_POP: begin
            heap[0] <= heap[ADDR_W'(size - CNT_W'(1))];
            cursor  <= '0;
          end
          OP_REPLACE: begin
            heap[0] <= in_data;
            cursor  <= '0;
          end
          default: cursor <= cursor;
        endcase
      end
      SIFT_UP: if (!up_term) begin
        heap[ADDR_W'(cursor)]     <= par_key;
        heap[ADDR_W'(parent_idx)] <= cur_key;
        cursor                    <= parent_idx;
      end
      SIFT_DOWN: if (!down_term) begin
        heap[ADDR_W'(cursor)]   <= best_key;
        heap[ADDR_W'(best_idx)] <= cur_key;
        cursor                  <= best_idx;
      end
      default: cursor <= cursor;
    endcase
  end

endmodule
